// File: rtl/labfinal_pio_in_edgecap.sv
// rtl/labfinal_pio_in_edgecap.sv - Avalon-MM input port with synchroniser, edge capture and irq
module labfinal_pio_in_edgecap #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_TYPE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] SETTLE_INIT = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clr;
  logic [2:0]       settle_cnt;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_writedata;

  assign sync             = sync_q[SYNC_STAGES-1];
  assign wr_en            = chipselect & ~write_n;
  assign rise             = sync & ~prev;
  assign fall             = ~sync & prev;
  assign unused_writedata = ^writedata;

  // Edges are masked until the settle counter drains so inputs already high at reset release don't capture.
  always_comb begin
    edge_vec = '0;
    if (settle_cnt == 3'd0) begin
      if (EDGE_TYPE == 0)      edge_vec = rise;
      else if (EDGE_TYPE == 1) edge_vec = fall;
      else                     edge_vec = rise | fall;
    end
  end

  always_comb begin
    clr = '0;
    if (wr_en && address == 2'd3) clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = sync;
      2'd2:    rd_next[WIDTH-1:0] = mask;
      2'd3:    rd_next[WIDTH-1:0] = edge_capture;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev         <= '0;
      mask         <= '0;
      edge_capture <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
      settle_cnt   <= SETTLE_INIT;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync;
      if (settle_cnt != 3'd0) settle_cnt <= settle_cnt - 3'd1;
      if (wr_en && address == 2'd2) mask <= writedata[WIDTH-1:0];
      // A new edge overrides a same-cycle clear of that bit.
      edge_capture <= (edge_capture & ~clr) | edge_vec;
      readdata     <= rd_next;
      if (IRQ_TYPE == 1) irq <= |(edge_capture & mask);
      else               irq <= |(sync & mask);
    end
  end

endmodule

// File: tb/tb_labfinal_pio_in_edgecap.sv
// tb/tb_labfinal_pio_in_edgecap.sv - self-checking bench for labfinal_pio_in_edgecap
module tb_labfinal_pio_in_edgecap;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance a: rising edges, edge irq. Instance b: any edge, level irq.
  labfinal_pio_in_edgecap #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_a), .irq(irq_a));

  labfinal_pio_in_edgecap #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_TYPE(0)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_b), .irq(irq_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sync is the input seen two edges earlier; edges count only once three
  // non-reset edges have passed since release.
  logic [7:0]  m_stage, m_sync, m_psync, m_mask;
  logic [7:0]  m_cap [2];
  logic [31:0] m_rd  [2];
  logic        m_irq [2];
  int          m_since;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0] clr_m, ev;
    if (reset) begin
      m_stage = '0; m_sync = '0; m_psync = '0; m_mask = '0; m_since = 0;
      for (int i = 0; i < 2; i++) begin
        m_cap[i] = '0; m_rd[i] = '0; m_irq[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      clr_m = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
      for (int i = 0; i < 2; i++) begin
        if (m_since < 3)  ev = 8'h00;
        else if (i == 0)  ev = m_sync & ~m_psync;
        else              ev = m_sync ^ m_psync;
        m_irq[i] = (i == 0) ? |(m_cap[i] & m_mask) : |(m_sync & m_mask);
        case (address)
          2'd0:    m_rd[i] = {24'h0, m_sync};
          2'd2:    m_rd[i] = {24'h0, m_mask};
          2'd3:    m_rd[i] = {24'h0, m_cap[i]};
          default: m_rd[i] = 32'h0;
        endcase
        m_cap[i] = (m_cap[i] & ~clr_m) | ev;
      end
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
      m_psync = m_sync;
      m_sync  = m_stage;
      m_stage = in_port;
      if (m_since < 1000) m_since++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_rd_a",  rd_a,  m_rd[0]);
      chk("model_irq_a", {31'h0, irq_a}, {31'h0, m_irq[0]});
      chk("model_rd_b",  rd_b,  m_rd[1]);
      chk("model_irq_b", {31'h0, irq_b}, {31'h0, m_irq[1]});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  initial begin
    reset = 1'b1; address = 2'd3; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'hFF;
    step(3);
    chk("reset_rd_a", rd_a, 32'h0);
    chk("reset_irq_a", {31'h0, irq_a}, 32'h0);
    chk("reset_irq_b", {31'h0, irq_b}, 32'h0);

    // Inputs high through reset release must not capture.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("settle_cap_a", rd_a, 32'h0);
      chk("settle_cap_b", rd_b, 32'h0);
      chk("settle_irq_a", {31'h0, irq_a}, 32'h0);
    end
    address = 2'd0;
    step(2);
    chk("settle_sync", rd_a, 32'hFF);

    // Single rising edge on bit 0 with mask 0x01.
    in_port = 8'h00;
    step(5);
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h01);
    address = 2'd3;
    step(2);
    in_port = 8'h01;
    step(3);
    chk("lat_irq_early", {31'h0, irq_a}, 32'h0);
    step(1);
    chk("lat_irq", {31'h0, irq_a}, 32'h1);
    chk("lat_cap", rd_a, 32'h1);

    // Clear collides with a fresh edge on bit 0: the bit survives.
    in_port = 8'h00;
    step(4);
    chk("hold_irq", {31'h0, irq_a}, 32'h1);
    in_port = 8'h01;
    step(2);
    bus_write(2'd3, 32'h1);
    address = 2'd3;
    chk("collide_irq0", {31'h0, irq_a}, 32'h1);
    step(1);
    chk("collide_irq1", {31'h0, irq_a}, 32'h1);
    chk("collide_cap", rd_a, 32'h1);

    // Plain clear drops irq one edge after the write edge.
    bus_write(2'd3, 32'h1);
    address = 2'd3;
    chk("clr_irq_w", {31'h0, irq_a}, 32'h1);
    step(1);
    chk("clr_irq", {31'h0, irq_a}, 32'h0);
    chk("clr_cap", rd_a, 32'h0);

    // Masked captures, ignored address-1 write, then unmask.
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'hFF);
    bus_write(2'd1, 32'hFF);
    address = 2'd3;
    in_port = 8'h29;
    step(5);
    chk("masked_cap", rd_a, 32'h28);
    chk("masked_irq", {31'h0, irq_a}, 32'h0);
    bus_write(2'd2, 32'h20);
    address = 2'd3;
    chk("unmask_irq_w", {31'h0, irq_a}, 32'h0);
    step(1);
    chk("unmask_irq", {31'h0, irq_a}, 32'h1);

    // Any-edge capture and level irq on bit 7.
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h80);
    address = 2'd3;
    step(2);
    in_port = 8'hA9;
    step(2);
    chk("lvl_irq_early", {31'h0, irq_b}, 32'h0);
    step(1);
    chk("lvl_irq_rise", {31'h0, irq_b}, 32'h1);
    step(1);
    chk("any_cap_rise", rd_b, 32'h80);
    chk("rise_irq_a", {31'h0, irq_a}, 32'h1);
    bus_write(2'd3, 32'hFF);
    address = 2'd3;
    step(1);
    chk("any_cap_clr", rd_b, 32'h0);
    in_port = 8'h29;
    step(2);
    chk("lvl_irq_hold", {31'h0, irq_b}, 32'h1);
    step(1);
    chk("lvl_irq_fall", {31'h0, irq_b}, 32'h0);
    step(1);
    chk("any_cap_fall", rd_b, 32'h80);

    // Reset mid-operation.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst_irq_a", {31'h0, irq_a}, 32'h0);
    chk("midrst_rd_b", rd_b, 32'h0);
    step(8);
    address = 2'd2;
    step(2);
    chk("midrst_mask", rd_a, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
